snes_serial_tx: RTL

//  Console-side serial transmitter for the emulated SNES controller. Takes the 16-bit

---
 rtl/snes_serial_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/snes_serial_tx.sv
// Console-side serial transmitter for the emulated SNES pad. Mimics the 4021 shift
// register chain: LATCH loads the button word, CLOCK rising edges shift it out on DATA.
// Console pins are asynchronous, so each one is synchronised and glitch-filtered first.
module snes_serial_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PULSE   = 4,
  parameter int unsigned NUM_BITS    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] button_data,
  input  logic                snes_latch,
  input  logic                snes_clk,
  output logic                snes_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned CntW  = $clog2(NUM_BITS + 1);
  localparam int unsigned FiltW = $clog2(MIN_PULSE + 1);

  localparam logic [CntW-1:0]  LastBit = CntW'(NUM_BITS - 1);
  localparam logic [CntW-1:0]  DoneCnt = CntW'(NUM_BITS);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(MIN_PULSE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   latch_filt_q;
  logic                   clk_filt_q;
  logic                   clk_prev_q;
  logic [FiltW-1:0]       latch_cnt_q;
  logic [FiltW-1:0]       clk_cnt_q;
  state_e                 state_q;
  logic [NUM_BITS-1:0]    shift_q;
  logic [NUM_BITS-1:0]    shifted;
  logic [CntW-1:0]        bit_cnt_q;
  logic                   clk_rise;

  // Pin synchronisers; CLOCK idles high so its chain resets to ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], snes_latch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], snes_clk};
    end
  end

  // LATCH filter: accept a new level only after MIN_PULSE consecutive differing cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_filt_q <= 1'b0;
      latch_cnt_q  <= '0;
    end else if (latch_sync_q[SYNC_STAGES-1] != latch_filt_q) begin
      if (latch_cnt_q == FiltMax) begin
        latch_filt_q <= latch_sync_q[SYNC_STAGES-1];
        latch_cnt_q  <= '0;
      end else begin
        latch_cnt_q <= latch_cnt_q + 1'b1;
      end
    end else begin
      latch_cnt_q <= '0;
    end
  end

  // CLOCK filter plus previous-level register for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      clk_cnt_q  <= '0;
    end else begin
      clk_prev_q <= clk_filt_q;
      if (clk_sync_q[SYNC_STAGES-1] != clk_filt_q) begin
        if (clk_cnt_q == FiltMax) begin
          clk_filt_q <= clk_sync_q[SYNC_STAGES-1];
          clk_cnt_q  <= '0;
        end else begin
          clk_cnt_q <= clk_cnt_q + 1'b1;
        end
      end else begin
        clk_cnt_q <= '0;
      end
    end
  end

  assign clk_rise = clk_filt_q & ~clk_prev_q;
  assign shifted  = {1'b0, shift_q[NUM_BITS-1:1]};

  // Frame FSM with registered DATA/busy/frame_done; a high LATCH always wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      snes_data  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (latch_filt_q) begin
            state_q   <= StLoad;
            shift_q   <= button_data;
            bit_cnt_q <= '0;
            snes_data <= ~button_data[0];
            busy      <= 1'b1;
          end
        end
        StLoad: begin
          if (latch_filt_q) begin
            // Parallel load follows the input for as long as LATCH is held
            shift_q   <= button_data;
            bit_cnt_q <= '0;
            snes_data <= ~button_data[0];
          end else begin
            state_q   <= StShift;
            snes_data <= ~shift_q[0];
          end
        end
        StShift: begin
          if (latch_filt_q) begin
            // Re-latch mid-frame: abandon the frame without a done pulse
            state_q   <= StLoad;
            shift_q   <= button_data;
            bit_cnt_q <= '0;
            snes_data <= ~button_data[0];
          end else if (clk_rise) begin
            shift_q <= shifted;
            if (bit_cnt_q == LastBit) begin
              state_q    <= StDone;
              bit_cnt_q  <= DoneCnt;
              snes_data  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              snes_data <= ~shifted[0];
            end
          end else begin
            snes_data <= ~shift_q[0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
